// File: rtl/aes_round_sequencer_pkg.sv
// Shared state encoding and AES sizing constants for the round sequencer.
package aes_seq_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} seq_state_e;

   localparam int AES_NR_128 = 10;
   localparam int AES_NR_192 = 12;
   localparam int AES_NR_256 = 14;
   localparam int BLOCK_W    = 128;
   localparam int RK_IDX_W   = 4;
endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-in / block-out valid-ready handshake between a producer and the sequencer.
interface aes_round_sequencer_if;
   import aes_seq_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] in_block;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out_block;

   modport master (
      output in_valid, in_block, out_ready,
      input  in_ready, out_valid, out_block
   );

   modport slave (
      input  in_valid, in_block, out_ready,
      output in_ready, out_valid, out_block
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller: whitening, round counting and key indexing around
// a shared external round datapath with fixed latency ROUND_LAT.
module aes_round_sequencer
   import aes_seq_pkg::*;
#(
   parameter int NR        = AES_NR_128,
   parameter int ROUND_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 scan_enable,
   aes_round_sequencer_if.slave bus,
   output logic [RK_IDX_W-1:0]  rk_idx,
   input  logic [BLOCK_W-1:0]   rk_data,
   output logic [BLOCK_W-1:0]   rnd_state,
   input  logic [BLOCK_W-1:0]   rnd_result,
   input  logic [BLOCK_W-1:0]   fin_result,
   output logic                 busy
);
   localparam int CNT_W = (ROUND_LAT < 1) ? 1 : $clog2(ROUND_LAT + 1);

   if (NR > 14 || NR < 2) begin : g_nr_check
      $error("aes_round_sequencer: NR must lie in 2..14");
   end

   seq_state_e          state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [RK_IDX_W-1:0] round, round_nxt;
   logic [BLOCK_W-1:0]  rnd_state_nxt;
   logic [BLOCK_W-1:0]  out_block_q, out_block_nxt;
   logic                out_valid_q, out_valid_nxt;
   logic                in_ready;
   logic                lat_done;

   assign lat_done      = (cnt == CNT_W'(ROUND_LAT));
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_block = out_block_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         round       <= '0;
         rnd_state   <= '0;
         out_block_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         round       <= round_nxt;
         rnd_state   <= rnd_state_nxt;
         out_block_q <= out_block_nxt;
         out_valid_q <= out_valid_nxt;
      end
   end

   // scan_enable gates every update so a frozen snapshot resumes exactly
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      round_nxt     = round;
      rnd_state_nxt = rnd_state;
      out_block_nxt = out_block_q;
      out_valid_nxt = out_valid_q;
      rk_idx        = '0;
      in_ready      = 1'b0;
      busy          = 1'b0;

      case (state)
         S_IDLE: begin
            in_ready = !scan_enable;
            if (bus.in_valid && !scan_enable) begin
               rnd_state_nxt = bus.in_block ^ rk_data;
               round_nxt     = RK_IDX_W'(1);
               cnt_nxt       = '0;
               state_nxt     = S_ROUND;
            end
         end
         S_ROUND: begin
            rk_idx = round;
            busy   = 1'b1;
            if (!scan_enable) begin
               if (lat_done) begin
                  rnd_state_nxt = rnd_result;
                  cnt_nxt       = '0;
                  round_nxt     = round + 1'b1;
                  if (round == RK_IDX_W'(NR - 1)) state_nxt = S_FINAL;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         S_FINAL: begin
            rk_idx = RK_IDX_W'(NR);
            busy   = 1'b1;
            if (!scan_enable) begin
               if (lat_done) begin
                  out_block_nxt = fin_result;
                  out_valid_nxt = 1'b1;
                  cnt_nxt       = '0;
                  state_nxt     = S_DONE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         S_DONE: begin
            if (bus.out_ready && !scan_enable) begin
               out_valid_nxt = 1'b0;
               state_nxt     = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench: AES-128 and AES-256 sequencers around a behavioural
// two-stage round datapath and key schedule, checked against known vectors.
module tb_aes_round_sequencer;
   import aes_seq_pkg::*;

   localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PTB   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CTB   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PTC   = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] CTC   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, scan, scan14;
   logic [3:0]   rk_idx, rk_idx14;
   logic [127:0] rk_data, rk_data14, rnd_state, rnd_state14;
   logic [127:0] rnd_result, rnd_result14, fin_result, fin_result14;
   logic         busy, busy14;
   logic [127:0] rk10 [16];
   logic [127:0] rk14 [16];
   logic [7:0]   sbox_t [256];
   logic [127:0] p1r, p2r, p1f, p2f, q1r, q2r, q1f, q2f;
   int           checks = 0;
   int           failures = 0;

   aes_round_sequencer_if bus();
   aes_round_sequencer_if bus14();

   aes_round_sequencer #(.NR(AES_NR_128), .ROUND_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .scan_enable(scan), .bus(bus),
      .rk_idx(rk_idx), .rk_data(rk_data), .rnd_state(rnd_state),
      .rnd_result(rnd_result), .fin_result(fin_result), .busy(busy)
   );

   aes_round_sequencer #(.NR(AES_NR_256), .ROUND_LAT(2)) dut14 (
      .clk(clk), .rst_n(rst_n), .scan_enable(scan14), .bus(bus14),
      .rk_idx(rk_idx14), .rk_data(rk_data14), .rnd_state(rnd_state14),
      .rnd_result(rnd_result14), .fin_result(fin_result14), .busy(busy14)
   );

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   // S-box from first principles: x^254 in GF(2^8), then the affine map
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul(b, x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = sbox_t[s[127-8*(4*((c+r)%4)+r) -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s);
      logic [127:0] o = '0;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] t);
      return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
   endfunction

   function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*r+4; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            rc = 8'h01;
            for (int j = 1; j < i/nk; j++) rc = xtime(rc);
            t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   task automatic load_key128(input logic [127:0] k);
      for (int r = 0; r < 16; r++) rk10[r] = (r <= 10) ? round_key({k, 128'h0}, 4, r) : '0;
   endtask

   task automatic load_key256(input logic [255:0] k);
      for (int r = 0; r < 16; r++) rk14[r] = (r <= 14) ? round_key(k, 8, r) : '0;
   endtask

   assign rk_data   = rk10[rk_idx];
   assign rk_data14 = rk14[rk_idx14];

   // Behavioural one_round / final_round, two register stages each
   always @(posedge clk) begin
      p1r <= mix(sub_shift(rnd_state)) ^ rk_data;
      p2r <= p1r;
      p1f <= sub_shift(rnd_state) ^ rk_data;
      p2f <= p1f;
      q1r <= mix(sub_shift(rnd_state14)) ^ rk_data14;
      q2r <= q1r;
      q1f <= sub_shift(rnd_state14) ^ rk_data14;
      q2f <= q1f;
   end
   assign rnd_result   = p2r;
   assign fin_result   = p2f;
   assign rnd_result14 = q2r;
   assign fin_result14 = q2f;

   // Called at a negedge; returns at the negedge just after the accept edge
   task automatic send_block(input logic [127:0] blk, output bit ok);
      int n = 0;
      bus.in_block = blk;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = (bus.in_ready === 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || busy !== 1'b0 || rk_idx !== 4'd0) begin
         failures++;
         $display("FAIL reset_ctrl in_ready=%b busy=%b rk_idx=%0d expected 1 0 0", bus.in_ready, busy, rk_idx);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_block !== '0 || rnd_state !== '0) begin
         failures++;
         $display("FAIL reset_data out_valid=%b out_block=%h rnd_state=%h expected zeros", bus.out_valid, bus.out_block, rnd_state);
      end
      checks++;
      if (bus14.in_ready !== 1'b1 || busy14 !== 1'b0) begin
         failures++;
         $display("FAIL reset_nr14 in_ready=%b busy=%b expected 1 0", bus14.in_ready, busy14);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fips128();
      bit ok;
      int k = 0;
      logic [3:0] exp_rk;
      bus.out_ready = 1'b1;
      send_block(PT, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL fips_accept in_ready never 1"); end
      while (bus.out_valid !== 1'b1 && k < 200) begin
         exp_rk = (k < 27) ? 4'(k/3 + 1) : 4'd10;
         checks++;
         if (rk_idx !== exp_rk || busy !== 1'b1) begin
            failures++;
            $display("FAIL fips_rk_seq k=%0d rk_idx=%0d busy=%b expected %0d 1", k, rk_idx, busy, exp_rk);
         end
         @(negedge clk);
         k++;
      end
      checks++;
      if (k != 30) begin failures++; $display("FAIL fips_latency got=%0d expected=30", k); end
      checks++;
      if (bus.out_block !== CT128) begin failures++; $display("FAIL fips_ct got=%h expected=%h", bus.out_block, CT128); end
      checks++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL fips_done in_ready=%b busy=%b expected 0 0", bus.in_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL fips_release out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int cyc;
      bus.out_ready = 1'b0;
      send_block(PT, ok);
      wait_out(cyc);
      checks++;
      if (!ok || cyc != 30) begin failures++; $display("FAIL bp_latency ok=%b got=%0d expected=30", ok, cyc); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_block !== CT128 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b out_block=%h expected 1 0 %h",
                     i, bus.out_valid, bus.in_ready, bus.out_block, CT128);
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_busy_input();
      bit ok;
      int cyc;
      load_key128(KB);
      bus.out_ready = 1'b1;
      send_block(PTB, ok);
      bus.in_block = PTC;
      bus.in_valid = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_ignore in_ready=%b busy=%b expected 0 1", bus.in_ready, busy);
      end
      wait_out(cyc);
      checks++;
      if (!ok || cyc + 5 != 30 || bus.out_block !== CTB) begin
         failures++;
         $display("FAIL busy_first lat=%0d out_block=%h expected 30 %h", cyc + 5, bus.out_block, CTB);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL busy_idle out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || rk_idx !== 4'd1) begin
         failures++;
         $display("FAIL busy_second_accept busy=%b rk_idx=%0d expected 1 1", busy, rk_idx);
      end
      wait_out(cyc);
      checks++;
      if (cyc != 30 || bus.out_block !== CTC) begin
         failures++;
         $display("FAIL busy_second lat=%0d out_block=%h expected 30 %h", cyc, bus.out_block, CTC);
      end
      @(negedge clk);
   endtask

   task automatic test_scan_freeze();
      bit ok;
      int cyc;
      load_key128(K128);
      scan = 1'b1;
      bus.in_block = PT;
      bus.in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL scan_idle in_ready=%b busy=%b expected 0 0", bus.in_ready, busy);
      end
      scan = 1'b0;
      send_block(PT, ok);
      repeat (10) @(negedge clk);
      checks++;
      if (!ok || rk_idx !== 4'd4 || dut.cnt !== 2'd1 || dut.round !== 4'd4) begin
         failures++;
         $display("FAIL scan_pre rk_idx=%0d cnt=%0d round=%0d expected 4 1 4", rk_idx, dut.cnt, dut.round);
      end
      scan = 1'b1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         checks++;
         if (rk_idx !== 4'd4 || dut.cnt !== 2'd1 || dut.round !== 4'd4) begin
            failures++;
            $display("FAIL scan_hold cyc=%0d rk_idx=%0d cnt=%0d round=%0d expected 4 1 4", i, rk_idx, dut.cnt, dut.round);
         end
      end
      scan = 1'b0;
      wait_out(cyc);
      checks++;
      if (cyc + 17 != 37 || bus.out_block !== CT128) begin
         failures++;
         $display("FAIL scan_result lat=%0d out_block=%h expected 37 %h", cyc + 17, bus.out_block, CT128);
      end
      scan = 1'b1;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL scan_out_hold out_valid=%b in_ready=%b expected 1 0", bus.out_valid, bus.in_ready);
      end
      scan = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL scan_out_release out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      int cyc;
      send_block(PT, ok);
      repeat (16) @(negedge clk);
      checks++;
      if (!ok || rk_idx !== 4'd6) begin failures++; $display("FAIL rst_pre rk_idx=%0d expected 6", rk_idx); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || rk_idx !== 4'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid out_valid=%b in_ready=%b rk_idx=%0d busy=%b expected 0 1 0 0",
                  bus.out_valid, bus.in_ready, rk_idx, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send_block(PT, ok);
      wait_out(cyc);
      checks++;
      if (!ok || cyc != 30 || bus.out_block !== CT128) begin
         failures++;
         $display("FAIL rst_next lat=%0d out_block=%h expected 30 %h", cyc, bus.out_block, CT128);
      end
      @(negedge clk);
   endtask

   task automatic test_nr14();
      int k = 0;
      logic [3:0] rk_final = '0;
      bus14.out_ready = 1'b1;
      bus14.in_block  = PT;
      bus14.in_valid  = 1'b1;
      checks++;
      if (bus14.in_ready !== 1'b1) begin failures++; $display("FAIL nr14_ready got=%b expected 1", bus14.in_ready); end
      @(negedge clk);
      bus14.in_valid = 1'b0;
      while (bus14.out_valid !== 1'b1 && k < 300) begin
         if (k == 41) rk_final = rk_idx14;
         @(negedge clk);
         k++;
      end
      checks++;
      if (k != 42 || rk_final !== 4'd14) begin
         failures++;
         $display("FAIL nr14_timing lat=%0d final_rk=%0d expected 42 14", k, rk_final);
      end
      checks++;
      if (bus14.out_block !== CT256) begin
         failures++;
         $display("FAIL nr14_ct got=%h expected=%h", bus14.out_block, CT256);
      end
      @(negedge clk);
      checks++;
      if (bus14.out_valid !== 1'b0 || bus14.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL nr14_release out_valid=%b in_ready=%b expected 0 1", bus14.out_valid, bus14.in_ready);
      end
   endtask

   initial begin
      rst_n           = 1'b0;
      scan            = 1'b0;
      scan14          = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_block    = '0;
      bus.out_ready   = 1'b1;
      bus14.in_valid  = 1'b0;
      bus14.in_block  = '0;
      bus14.out_ready = 1'b1;
      for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
      load_key128(K128);
      load_key256(K256);
      test_reset();
      test_fips128();
      test_backpressure();
      test_busy_input();
      test_scan_freeze();
      test_reset_mid_op();
      test_nr14();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
